// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// Optional combinational flag forwarding is enabled by defining FLAG_BYPASS_EN.
package ex_mem_pkg;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  localparam int XZR = 31;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  localparam mem_ctrl_t CTRL_BUBBLE = '0;

  function automatic nzcv_t unpack_nzcv(input logic [3:0] f);
    nzcv_t r;
    r.n = f[NZCV_N];
    r.z = f[NZCV_Z];
    r.c = f[NZCV_C];
    r.v = f[NZCV_V];
    return r;
  endfunction

  // A write to XZR is discarded, but a store whose data register is XZR is still a store.
  function automatic mem_ctrl_t qualify_ctrl(input logic valid, input logic to_xzr,
                                             input logic reg_write, input logic mem_read,
                                             input logic mem_write);
    mem_ctrl_t r;
    r.reg_write = valid & reg_write & ~to_xzr;
    r.mem_read  = valid & mem_read;
    r.mem_write = valid & mem_write;
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_stage_nzcv_reg.sv
// Architectural NZCV flag register with load enable and synchronous reset.
// With FLAG_BYPASS_EN defined the output forwards the execute-stage flags combinationally.
module nzcv_reg
  import ex_mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  upd,
  input  nzcv_t d,
  output nzcv_t q
);

  nzcv_t flags_p1;
  logic  load;

  // upd already excludes flush; a stalled update waits for the instruction to advance.
  assign load = upd & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_p1 <= '0;
    end else if (load) begin
      flags_p1 <= d;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign q = upd ? d : flags_p1;
`else
  assign q = flags_p1;
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register of the LEGv8 core: data, destination, control and NZCV flags.
// Build option FLAG_BYPASS_EN forwards execute-stage flags straight to nzcv.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      ex_set_flags,
  input  logic [3:0]                ex_nzcv,
  output logic                      mem_valid,
  output logic [DATA_WIDTH-1:0]     mem_result,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic [3:0]                nzcv
);

  localparam logic [REG_ADDR_WIDTH-1:0] RD_XZR = REG_ADDR_WIDTH'(XZR);

  logic                      vld_p1;
  mem_ctrl_t                 ctrl_p1;
  logic [DATA_WIDTH-1:0]     result_p1;
  logic [DATA_WIDTH-1:0]     store_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;

  mem_ctrl_t ctrl_p0;
  logic      flag_upd_p0;
  nzcv_t     nzcv_p0;
  nzcv_t     flags_q;

  assign ctrl_p0     = qualify_ctrl(ex_valid, ex_rd == RD_XZR,
                                    ex_reg_write, ex_mem_read, ex_mem_write);
  assign flag_upd_p0 = ex_valid & ex_set_flags & ~flush;
  assign nzcv_p0     = unpack_nzcv(ex_nzcv);

  // ---- EX -> MEM boundary: control ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_BUBBLE;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_BUBBLE;
    end else if (!stall) begin
      vld_p1  <= ex_valid;
      ctrl_p1 <= ctrl_p0;
    end
  end

  // ---- EX -> MEM boundary: data (bubbles load zeros so nothing downstream sees X) ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      result_p1 <= '0;
      store_p1  <= '0;
      rd_p1     <= '0;
    end else if (!stall) begin
      result_p1 <= ex_result;
      store_p1  <= ex_store_data;
      rd_p1     <= ex_rd;
    end
  end

  nzcv_reg u_nzcv_reg (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .upd   (flag_upd_p0),
    .d     (nzcv_p0),
    .q     (flags_q)
  );

  assign mem_valid      = vld_p1;
  assign mem_result     = result_p1;
  assign mem_store_data = store_p1;
  assign mem_rd         = rd_p1;
  assign mem_reg_write  = ctrl_p1.reg_write;
  assign mem_mem_read   = ctrl_p1.mem_read;
  assign mem_mem_write  = ctrl_p1.mem_write;
  assign nzcv           = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed test-plan sequence followed by random traffic.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset, stall, flush;
  logic        ex_valid;
  logic [63:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_set_flags;
  logic [3:0]  ex_nzcv;
  logic        mem_valid;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write;
  logic [3:0]  nzcv;

  ex_mem_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_set_flags(ex_set_flags), .ex_nzcv(ex_nzcv),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .nzcv(nzcv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [63:0] result;
    logic [63:0] store;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [3:0]  flags;
    logic        known;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: architectural meaning of one clock edge for the stage.
  task automatic model_edge();
    if (reset) begin
      m.valid = 0; m.result = 0; m.store = 0; m.rd = 0;
      m.rw = 0; m.mr = 0; m.mw = 0; m.flags = 0; m.known = 1;
    end else if (flush) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.known = 0;
    end else if (!stall) begin
      m.valid  = ex_valid;
      m.result = ex_result;
      m.store  = ex_store_data;
      m.rd     = ex_rd;
      m.rw     = ex_valid && ex_reg_write && (ex_rd != 5'd31);
      m.mr     = ex_valid && ex_mem_read;
      m.mw     = ex_valid && ex_mem_write;
      if (ex_valid && ex_set_flags) m.flags = ex_nzcv;
      m.known  = 1;
    end
    q.push_back(m);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [63:0] sd,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic sf, input logic [3:0] nz,
                       input logic st, input logic fl, input logic rs);
    ex_valid = v; ex_result = res; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_set_flags = sf; ex_nzcv = nz; stall = st; flush = fl; reset = rs;
  endtask

  // Monitor: every edge presents a new stage state; compare it at the falling edge.
  initial begin
    exp_t e;
    logic [3:0] nz_exp;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mem_valid", {63'd0, mem_valid}, {63'd0, e.valid});
        chk("mem_reg_write", {63'd0, mem_reg_write}, {63'd0, e.rw});
        chk("mem_mem_read", {63'd0, mem_mem_read}, {63'd0, e.mr});
        chk("mem_mem_write", {63'd0, mem_mem_write}, {63'd0, e.mw});
        if (e.known) begin
          chk("mem_result", mem_result, e.result);
          chk("mem_store_data", mem_store_data, e.store);
          chk("mem_rd", {59'd0, mem_rd}, {59'd0, e.rd});
        end else begin
          chk("bubble_data_known",
              {63'd0, $isunknown({mem_result, mem_store_data, mem_rd})}, 64'd0);
        end
        nz_exp = e.flags;
`ifdef FLAG_BYPASS_EN
        if (ex_valid && ex_set_flags && !flush) nz_exp = ex_nzcv;
`endif
        chk("nzcv", {60'd0, nzcv}, {60'd0, nz_exp});
      end
    end
  end

  initial begin
    int pct;
    logic [4:0] rrd;
    m = '{valid: 0, result: 0, store: 0, rd: 0, rw: 0, mr: 0, mw: 0, flags: 0, known: 0};

    // Reset with every input high
    drive(1, '1, '1, 5'd31, 1, 1, 1, 1, 4'hF, 1, 1, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    // Plain capture
    drive(1, 64'hDEAD_BEEF_0000_0001, 64'h1234, 5'd3, 1, 0, 0, 0, 4'h0, 0, 0, 0);
    cyc();
    // STUR-like to XZR: store kept, reg write dropped
    drive(1, 64'h40, 64'hCAFE, 5'd31, 1, 0, 1, 0, 4'h0, 0, 0, 0);
    cyc();

    // rd=5 then three stalled cycles with changing inputs, then stall+flush
    drive(1, 64'h55, 64'h66, 5'd5, 1, 1, 0, 0, 4'h0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 30)),
            1, 1, 1, 1, 4'($urandom), 1, 0, 0);
      cyc();
    end
    drive(1, 64'h77, 64'h88, 5'd7, 1, 1, 1, 0, 4'h0, 1, 1, 0);
    cyc();

    // SUBS setting 0110, then a flushed flag-setter, then set_flags without valid
    drive(1, 64'h0, 64'h0, 5'd9, 1, 0, 0, 1, 4'b0110, 0, 0, 0);
    cyc();
    drive(1, 64'h1, 64'h0, 5'd10, 1, 0, 0, 1, 4'b1001, 0, 1, 0);
    cyc();
    drive(0, 64'h2, 64'h0, 5'd11, 1, 1, 1, 1, 4'b1111, 0, 0, 0);
    cyc();
    // Back-to-back flag setters, then stalled setter held off
    drive(1, 64'h3, 64'h0, 5'd12, 1, 0, 0, 1, 4'b1000, 0, 0, 0);
    cyc();
    drive(1, 64'h4, 64'h0, 5'd13, 1, 0, 0, 1, 4'b0011, 0, 0, 0);
    cyc();
    drive(1, 64'h5, 64'h0, 5'd14, 1, 0, 0, 1, 4'b0101, 1, 0, 0);
    cyc();

    // Reset during stall+flush, then release under stall, then capture
    drive(1, 64'h9, 64'h9, 5'd1, 1, 1, 1, 1, 4'hA, 1, 1, 1);
    cyc();
    drive(1, 64'hA, 64'hA, 5'd2, 1, 1, 1, 1, 4'hB, 1, 0, 0);
    cyc();
    drive(1, 64'hB, 64'hB, 5'd4, 1, 1, 1, 1, 4'hC, 0, 0, 0);
    cyc();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      pct = $urandom_range(0, 99);
      rrd = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom);
      drive($urandom_range(0, 9) < 8, {$urandom, $urandom}, {$urandom, $urandom}, rrd,
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) < 4,
            4'($urandom), pct < 25, $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 3);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register between the execute stage (ALU and its bitwise/arithmetic units) and the memory stage of the LEGv8 core. Captures the ALU result, store data, destination register and memory/writeback control each cycle. Holds the architectural NZCV condition-flag register updated by flag-setting instructions. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- DATA_WIDTH, 64, width of result and store-data buses
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all state this cycle
- flush  in  1  load a bubble this cycle
- ex_valid  in  1  execute stage holds a real instruction
- ex_result  in  DATA_WIDTH  ALU output
- ex_store_data  in  DATA_WIDTH  register value for STUR
- ex_rd  in  REG_ADDR_WIDTH  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- ex_set_flags  in  1  instruction updates NZCV (ADDS/SUBS/ANDS)
- ex_nzcv  in  4  ALU flags, bit3=N, bit2=Z, bit1=C, bit0=V
- mem_valid  out  1  registered ex_valid
- mem_result, mem_store_data  out  DATA_WIDTH  registered data
- mem_rd  out  REG_ADDR_WIDTH  registered destination
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control
- nzcv  out  4  condition flags presented to branch logic

## Operation
- Update priority each rising edge: reset > flush > stall > capture.
- reset: every output register and the flag register go to 0.
- flush (stall ignored): mem_valid and all three control outputs go to 0. mem_result, mem_store_data and mem_rd are don't-care but must not be X. The flag register is held.
- stall without flush: every register, including flags, holds its value.
- capture: all ex_* fields load into the mem_* registers.
  - Control bits are qualified by ex_valid. When ex_valid=0, the control outputs load 0.
  - If ex_rd equals XZR (31), mem_reg_write loads 0.
- Flag register: loads ex_nzcv when ex_valid & ex_set_flags & !stall & !flush & !reset. Otherwise it holds.
- A STUR to XZR remains a store. The XZR rule clears only reg_write.
- No arithmetic is performed in this block. Widths pass through unchanged.

## Timing
- Latency is 1 cycle from ex_* to mem_*.
- nzcv from the register: a flag-setting instruction captured at edge k is visible after edge k.
- stall and flush are sampled at the same edge as the data. Their effect appears after that edge.
- Reset asserted mid-stall or mid-flush wins on that edge. Outputs are 0 from the following cycle.
- Reset deasserted: the first capture happens on the next edge with stall=0.
- Back-to-back flag-setting instructions: the last one captured wins. Each one updates the register once.

## Configuration
- FLAG_BYPASS_EN defined: nzcv is combinational.
  - It equals ex_nzcv when ex_valid & ex_set_flags & !flush.
  - Otherwise it equals the flag register.
  - A B.cond in decode sees flags from the instruction currently in execute with no bubble.
- FLAG_BYPASS_EN undefined: nzcv is the flag register output only. Flags from the execute-stage instruction appear one cycle later, and the hazard unit inserts one stall.

## Structure
- Shared package ex_mem_pkg:
  - nzcv_t packed struct {n, z, c, v}
  - constant XZR = 31
  - localparams for flag bit indices
  - mem_ctrl_t packed struct {reg_write, mem_read, mem_write}
- Sub-module nzcv_reg: 4-bit flag register with load enable and synchronous reset, plus the optional bypass mux.

## Test plan
- Reset with all inputs at 1 -> every mem_* output and nzcv equal 0 on the next cycle.
- Capture ex_result=64'hDEAD_BEEF_0000_0001, ex_rd=3, ex_reg_write=1, ex_valid=1 -> next cycle mem_result matches, mem_rd=3, mem_reg_write=1, mem_valid=1.
- ex_rd=31 with ex_reg_write=1 and ex_mem_write=1 -> mem_reg_write=0, mem_mem_write=1.
- Register loaded with rd=5, then stall=1 for 3 cycles with changing ex inputs -> outputs still rd=5. Then stall=1 with flush=1 -> mem_valid=0 and all control bits 0.
- SUBS with ex_nzcv=4'b0110 -> after the edge nzcv=4'b0110. With FLAG_BYPASS_EN, nzcv=4'b0110 already in the same cycle. Repeat with flush=1 -> flags unchanged.
- ex_set_flags=1 with ex_valid=0 -> flags unchanged and control outputs 0.
